// File: rtl/lcd2002_pkg.sv
// Shared definitions for the HD44780 20x2 driver: command bytes, FSM states,
// and helpers for the init command order and character extraction.
package lcd2002_pkg;

  localparam int LCD_COLS   = 20;
  localparam int LCD_LINE_W = LCD_COLS * 8;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    POWERUP,
    INIT,
    CLR_WAIT,
    ADDR1,
    ROW1,
    ADDR2,
    ROW2
  } lcd_state_e;

  function automatic logic [7:0] init_cmd(input logic [1:0] k);
    case (k)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

  // Character 0 is the leftmost, held in the top byte of the line.
  function automatic logic [7:0] char_at(input logic [LCD_LINE_W-1:0] line,
                                         input logic [4:0] k);
    return line[8*(LCD_COLS-1-int'(k)) +: 8];
  endfunction

endpackage

// File: rtl/lcd2002_driver_tick.sv
// Step tick generator: one-cycle pulse every TICK_CYCLES clocks, first pulse
// TICK_CYCLES cycles after reset release.
module lcd_tick_gen #(
  parameter int TICK_CYCLES = 50000
) (
  input  logic Clk,
  input  logic Rst,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CW'(TICK_CYCLES - 1));
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd2002_driver.sv
// HD44780 20x2 write-only driver: one-time init, then endless refresh of both
// lines from per-pass snapshots; every byte is a two-tick E strobe.
module lcd2002_driver
  import lcd2002_pkg::*;
#(
  parameter int TICK_CYCLES   = 50000,
  parameter int POWERUP_TICKS = 20,
  parameter int CLEAR_TICKS   = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  output logic                  LCD_rw,
  output logic                  LCD_E,
  output logic                  LCD_rs,
  output logic [7:0]            LCD_data,
  input  logic [LCD_LINE_W-1:0] row_1,
  input  logic [LCD_LINE_W-1:0] row_2
);

  logic tick;

  lcd_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .Clk  (Clk),
    .Rst  (Rst),
    .tick (tick)
  );

  lcd_state_e            state_q;
  logic                  ph_q;      // 0: next tick is phase A (E rise)
  logic [4:0]            idx_q;
  logic [15:0]           wait_q;
  logic [LCD_LINE_W-1:0] line_q;
  logic                  e_q, rs_q;
  logic [7:0]            data_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= POWERUP;
      ph_q    <= 1'b0;
      idx_q   <= '0;
      wait_q  <= '0;
      line_q  <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else if (tick) begin
      case (state_q)
        POWERUP, CLR_WAIT: begin
          e_q <= 1'b0;
          if (wait_q + 16'd1 >= 16'((state_q == POWERUP) ? POWERUP_TICKS : CLEAR_TICKS)) begin
            wait_q  <= '0;
            state_q <= (state_q == POWERUP) ? INIT : ADDR1;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        INIT: begin
          if (!ph_q) begin
            e_q    <= 1'b1;
            rs_q   <= 1'b0;
            data_q <= init_cmd(idx_q[1:0]);
            ph_q   <= 1'b1;
          end else begin
            e_q  <= 1'b0;
            ph_q <= 1'b0;
            if (idx_q == 5'd3) begin
              idx_q   <= '0;
              state_q <= CLR_WAIT;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        ADDR1, ADDR2: begin
          if (!ph_q) begin
            e_q    <= 1'b1;
            rs_q   <= 1'b0;
            data_q <= (state_q == ADDR1) ? LCD_LINE1 : LCD_LINE2;
            line_q <= (state_q == ADDR1) ? row_1 : row_2;
            ph_q   <= 1'b1;
          end else begin
            e_q     <= 1'b0;
            ph_q    <= 1'b0;
            state_q <= (state_q == ADDR1) ? ROW1 : ROW2;
          end
        end
        ROW1, ROW2: begin
          if (!ph_q) begin
            e_q    <= 1'b1;
            rs_q   <= 1'b1;
            data_q <= char_at(line_q, idx_q);
            ph_q   <= 1'b1;
          end else begin
            e_q  <= 1'b0;
            ph_q <= 1'b0;
            if (idx_q == 5'(LCD_COLS - 1)) begin
              idx_q   <= '0;
              state_q <= (state_q == ROW1) ? ADDR2 : ADDR1;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        default: state_q <= POWERUP;
      endcase
    end
  end

  assign LCD_rw   = 1'b0;
  assign LCD_E    = e_q;
  assign LCD_rs   = rs_q;
  assign LCD_data = data_q;

endmodule

// File: tb/tb_lcd2002_driver.sv
// Bench for lcd2002_driver: random row text checked against a byte-stream
// model of the panel protocol, plus strobe timing and async reset.
module tb_lcd2002_driver;

  localparam int TICK = 4;
  localparam int PWR  = 2;
  localparam int CLRT = 2;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         LCD_rw, LCD_E, LCD_rs;
  logic [7:0]   LCD_data;
  logic [159:0] row_1, row_2;

  lcd2002_driver #(
    .TICK_CYCLES   (TICK),
    .POWERUP_TICKS (PWR),
    .CLEAR_TICKS   (CLRT)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .LCD_rw   (LCD_rw),
    .LCD_E    (LCD_E),
    .LCD_rs   (LCD_rs),
    .LCD_data (LCD_data),
    .row_1    (row_1),
    .row_2    (row_2)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: the expected byte stream as {rs,data}; each line block is queued
  // when its address command strobes, using the row text present at that moment.
  logic [8:0]  exp_q[$];
  bit          next_l2, in_l2, prev_e, prev_rs;
  logic [7:0]  prev_d;
  int          cyc_rel, e_high, rise_cnt, last80, fall01, blk_chars;
  int          blocks_done = 0;

  task automatic refill();
    logic [159:0] r;
    r = next_l2 ? row_2 : row_1;
    exp_q.push_back({1'b0, next_l2 ? 8'hC0 : 8'h80});
    for (int k = 0; k < 20; k++) exp_q.push_back({1'b1, r[159-8*k -: 8]});
    in_l2   = next_l2;
    next_l2 = !next_l2;
  endtask

  always begin
    @(posedge Clk);
    #1;
    if (Rst) begin
      exp_q.delete();
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h06});
      exp_q.push_back({1'b0, 8'h01});
      next_l2 = 0; in_l2 = 0; prev_e = 0; prev_rs = 0; prev_d = 0;
      cyc_rel = 0; e_high = 0; rise_cnt = 0; last80 = -1; fall01 = -1; blk_chars = 0;
    end else begin
      cyc_rel++;
      chk("rw_low", LCD_rw, 0);
      if (cyc_rel < (PWR + 1) * TICK)
        chk("pwrup_idle", {LCD_E, LCD_rs, LCD_data}, 0);
      if (LCD_E && !prev_e) begin
        rise_cnt++;
        e_high = 1;
        if (rise_cnt == 1) chk("first_rise_cyc", cyc_rel, (PWR + 1) * TICK);
        if (exp_q.size() == 0) begin
          refill();
          blk_chars = 0;
        end
        if (LCD_data == 8'h80 && !LCD_rs) begin
          if (last80 >= 0) chk("refresh_period", cyc_rel - last80, 84 * TICK);
          else             chk("clr_gap", cyc_rel - fall01, (CLRT + 1) * TICK);
          last80 = cyc_rel;
        end
      end else if (LCD_E) begin
        e_high++;
        chk("stable_dat", LCD_data, prev_d);
        chk("stable_rs", LCD_rs, prev_rs);
      end else if (prev_e) begin
        chk("e_width", e_high, TICK);
        chk("hold_dat", {LCD_rs, LCD_data}, {prev_rs, prev_d});
        if (exp_q.size() == 0) chk("extra_byte", {LCD_rs, LCD_data}, 9'h1FF);
        else chk(LCD_rs ? "char" : "cmd", {LCD_rs, LCD_data}, exp_q.pop_front());
        if (!LCD_rs && LCD_data == 8'h01) fall01 = cyc_rel;
        if (LCD_rs) begin
          blk_chars++;
          if (blk_chars == 20) blocks_done++;
        end
      end
      prev_e  = LCD_E;
      prev_d  = LCD_data;
      prev_rs = LCD_rs;
    end
  end

  task automatic wait_blocks(input int target, input string tag);
    int i;
    for (i = 0; i < 4000 && blocks_done < target; i++) @(negedge Clk);
    chk(tag, blocks_done >= target, 1);
  endtask

  initial begin
    logic [159:0] r1, r2;
    int base, i;
    row_1 = "   Cheak SW all on  ";
    row_2 = " and push S1 button ";
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    wait_blocks(3, "to_first_pass");

    // Change line 1 mid-pass: this pass keeps old text, the next shows new.
    for (i = 0; i < 4000 && !(!in_l2 && blk_chars >= 7 && blk_chars < 15); i++) @(negedge Clk);
    chk("to_mid_row1", !in_l2 && blk_chars >= 7, 1);
    row_1 = " Never gonna        ";
    base = blocks_done;
    wait_blocks(base + 4, "to_snapshot");

    // Random text (any byte value) changed at random times.
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 20; k++) begin
        r1[159-8*k -: 8] = 8'($urandom);
        r2[159-8*k -: 8] = 8'($urandom_range(32, 126));
      end
      repeat ($urandom_range(1, 400)) @(negedge Clk);
      if ($urandom_range(0, 1) == 1) row_1 = r1;
      else                           row_2 = r2;
    end
    base = blocks_done;
    wait_blocks(base + 2, "to_random");

    // Asynchronous reset while E is high during line 2.
    for (i = 0; i < 4000 && !(in_l2 && LCD_E && LCD_rs); i++) @(negedge Clk);
    chk("to_row2_strobe", in_l2 && LCD_E && LCD_rs, 1);
    #2;
    Rst = 1'b1;
    #1;
    chk("rst_e", LCD_E, 0);
    chk("rst_rs", LCD_rs, 0);
    chk("rst_dat", LCD_data, 0);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    base = blocks_done;
    wait_blocks(base + 3, "to_restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
